// File: rtl/rr_mux_arbiter_pkg.sv
// Shared helpers for the round-robin mux arbiter: pointer sizing and the
// elaboration-time index width check.
package rr_mux_arbiter_pkg;

   function automatic int ptr_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   function automatic bit index_width_ok(input int size, input int index_width);
      return index_width >= ptr_width(size);
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle for the arbiter: SIZE elastic producers in, data and
// index elastic channels out.
interface rr_mux_arbiter_if #(
   parameter int SIZE        = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 1
);
   import rr_mux_arbiter_pkg::*;

   logic [SIZE*DATA_WIDTH-1:0] ins;
   logic [SIZE-1:0]            ins_valid;
   logic [SIZE-1:0]            ins_ready;
   logic [DATA_WIDTH-1:0]      outs;
   logic                       outs_valid;
   logic                       outs_ready;
   logic [INDEX_WIDTH-1:0]     index;
   logic                       index_valid;
   logic                       index_ready;

   modport master (
      output ins, ins_valid, outs_ready, index_ready,
      input  ins_ready, outs, outs_valid, index, index_valid
   );

   modport slave (
      input  ins, ins_valid, outs_ready, index_ready,
      output ins_ready, outs, outs_valid, index, index_valid
   );
endinterface

// File: rtl/rr_mux_arbiter_rr_arbiter.sv
// Rotating-priority picker: scans requests starting at ptr and advances ptr
// past the winner whenever a grant is actually taken.
module rr_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter  int SIZE  = 2,
   localparam int PTR_W = ptr_width(SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SIZE-1:0]  req,
   input  logic             grant_en,
   output logic [SIZE-1:0]  grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [PTR_W-1:0] ptr;
   logic             found;
   int               cand;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
      if (int'(idx) >= SIZE - 1) return '0;
      return idx + 1'b1;
   endfunction

   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int k = 0; k < SIZE; k++) begin
         cand = int'(ptr) + k;
         if (cand >= SIZE) cand = cand - SIZE;
         if (!found && req[cand]) begin
            found     = 1'b1;
            grant_idx = PTR_W'(cand);
         end
      end
      grant_any = found;
      grant     = (grant_en && found) ? (SIZE'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (grant_en && found)
         ptr <= next_ptr(grant_idx);
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered slot between SIZE producers,
// forking the result into independent data and index channels.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int SIZE        = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 1
) (
   input logic            clk,
   input logic            rst,
   rr_mux_arbiter_if.slave bus
);

   localparam int PTR_W = ptr_width(SIZE);

   if (!index_width_ok(SIZE, INDEX_WIDTH)) begin : g_width_check
      $error("rr_mux_arbiter: INDEX_WIDTH too small for SIZE");
   end

   logic [DATA_WIDTH-1:0]  data_r;
   logic [INDEX_WIDTH-1:0] idx_r;
   logic                   pend_d;
   logic                   pend_i;
   logic                   slot_empty;
   logic                   done_now;
   logic                   load_ok;
   logic [PTR_W-1:0]       grant_idx;
   logic                   grant_any;
   logic [DATA_WIDTH-1:0]  win_data;

   function automatic logic [INDEX_WIDTH-1:0] zext_idx(input logic [PTR_W-1:0] idx);
      return INDEX_WIDTH'(idx);
   endfunction

   assign slot_empty = !pend_d && !pend_i;
   assign done_now   = (!pend_d || bus.outs_ready) && (!pend_i || bus.index_ready);
   assign load_ok    = (slot_empty || done_now) && !rst;
   assign win_data   = bus.ins[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

   rr_arbiter #(.SIZE(SIZE)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.ins_valid),
      .grant_en  (load_ok),
      .grant     (bus.ins_ready),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Each half of the fork retires on its own ready; a fresh load overrides both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= '0;
         idx_r  <= '0;
         pend_d <= 1'b0;
         pend_i <= 1'b0;
      end else if (load_ok && grant_any) begin
         data_r <= win_data;
         idx_r  <= zext_idx(grant_idx);
         pend_d <= 1'b1;
         pend_i <= 1'b1;
      end else begin
         if (bus.outs_ready)  pend_d <= 1'b0;
         if (bus.index_ready) pend_i <= 1'b0;
      end
   end

   assign bus.outs        = data_r;
   assign bus.outs_valid  = pend_d;
   assign bus.index       = idx_r;
   assign bus.index_valid = pend_i;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a SIZE=4 instance for arbitration and
// fork behaviour plus a SIZE=1 instance for the degenerate pass-through case.
module tb_rr_mux_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rr_mux_arbiter_if #(.SIZE(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) bus4 ();
   rr_mux_arbiter_if #(.SIZE(1), .DATA_WIDTH(32), .INDEX_WIDTH(1)) bus1 ();

   rr_mux_arbiter #(.SIZE(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   rr_mux_arbiter #(.SIZE(1), .DATA_WIDTH(32), .INDEX_WIDTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [3:0] valid, input logic o_rdy, input logic i_rdy);
      bus4.ins_valid   = valid;
      bus4.outs_ready  = o_rdy;
      bus4.index_ready = i_rdy;
      #1;
   endtask

   initial begin
      logic [3:0] exp_rdy;
      checks = 0;
      errors = 0;

      rst              = 1'b1;
      bus4.ins         = {32'h13, 32'h12, 32'h11, 32'h10};
      bus1.ins         = '0;
      bus1.ins_valid   = 1'b0;
      bus1.outs_ready  = 1'b1;
      bus1.index_ready = 1'b1;
      apply_stimulus(4'hF, 1'b1, 1'b1);

      // Reset state, with all inputs valid to show ins_ready is held low.
      check_output("rst_outs_valid", bus4.outs_valid, 0);
      check_output("rst_index_valid", bus4.index_valid, 0);
      check_output("rst_outs", bus4.outs, 0);
      check_output("rst_index", bus4.index, 0);
      check_output("rst_ins_ready", bus4.ins_ready, 0);
      tick();
      tick();
      check_output("rst_hold_ins_ready", bus4.ins_ready, 0);
      rst = 1'b0;
      #1;

      // Fairness: full throughput, index rotates 0..3.
      check_output("fair_first_ready", bus4.ins_ready, 4'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         exp_rdy = 4'b0001 << ((k + 1) % 4);
         check_output("fair_index", bus4.index, k % 4);
         check_output("fair_outs", bus4.outs, 32'h10 + (k % 4));
         check_output("fair_valid", {bus4.outs_valid, bus4.index_valid}, 2'b11);
         check_output("fair_ready", bus4.ins_ready, exp_rdy);
      end

      // Drain with no valid inputs; then land ptr on 1.
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      tick();
      check_output("idle_outs_valid", bus4.outs_valid, 0);
      check_output("idle_index_valid", bus4.index_valid, 0);
      apply_stimulus(4'b0001, 1'b1, 1'b1);
      tick();
      check_output("prep_index", bus4.index, 0);

      // Skip idle: ptr=1 with only ch3 and ch0 valid.
      apply_stimulus(4'b1001, 1'b1, 1'b1);
      check_output("skip_ready_a", bus4.ins_ready, 4'b1000);
      tick();
      check_output("skip_index_a", bus4.index, 3);
      check_output("skip_ready_b", bus4.ins_ready, 4'b0001);
      tick();
      check_output("skip_index_b", bus4.index, 0);
      check_output("skip_ready_c", bus4.ins_ready, 4'b1000);

      // Split fork: token idx 2 / 0xAB, index channel stalled three cycles.
      bus4.ins[2*32 +: 32] = 32'hAB;
      apply_stimulus(4'b0100, 1'b1, 1'b1);
      tick();
      check_output("split_load_index", bus4.index, 2);
      check_output("split_load_outs", bus4.outs, 32'hAB);
      apply_stimulus(4'b1111, 1'b1, 1'b0);
      check_output("split_ready_pre", bus4.ins_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_output("split_outs_valid", bus4.outs_valid, 0);
         check_output("split_index_valid", bus4.index_valid, 1);
         check_output("split_index", bus4.index, 2);
         check_output("split_ready", bus4.ins_ready, 0);
      end
      apply_stimulus(4'b1111, 1'b1, 1'b1);
      check_output("split_release_ready", bus4.ins_ready, 4'b1000);
      tick();
      check_output("split_next_index", bus4.index, 3);
      check_output("split_next_outs", bus4.outs, 32'h13);
      check_output("split_next_valid", bus4.outs_valid, 1);

      // Backpressure on both channels for five cycles.
      apply_stimulus(4'b1111, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check_output("bp_ready", bus4.ins_ready, 0);
         tick();
         check_output("bp_outs", bus4.outs, 32'h13);
         check_output("bp_index", bus4.index, 3);
         check_output("bp_valid", {bus4.outs_valid, bus4.index_valid}, 2'b11);
      end
      apply_stimulus(4'b1111, 1'b1, 1'b1);
      check_output("bp_release_ready", bus4.ins_ready, 4'b0001);
      tick();
      check_output("bp_next_index", bus4.index, 0);
      check_output("bp_next_outs", bus4.outs, 32'h10);

      // Reset mid-token, asserted between edges; ptr was 1 beforehand.
      apply_stimulus(4'b0011, 1'b0, 1'b0);
      check_output("mid_pend", bus4.outs_valid, 1);
      check_output("mid_ptr_ready", bus4.ins_ready, 0);
      #1;
      rst = 1'b1;
      #1;
      check_output("mid_rst_outs_valid", bus4.outs_valid, 0);
      check_output("mid_rst_index_valid", bus4.index_valid, 0);
      check_output("mid_rst_outs", bus4.outs, 0);
      check_output("mid_rst_ready", bus4.ins_ready, 0);
      #1;
      rst = 1'b0;
      apply_stimulus(4'b0011, 1'b1, 1'b1);
      check_output("post_rst_ready", bus4.ins_ready, 4'b0001);
      tick();
      check_output("post_rst_index", bus4.index, 0);
      check_output("post_rst_outs", bus4.outs, 32'h10);

      // SIZE=1: data passes through, index is always 0.
      for (int k = 0; k < 3; k++) begin
         bus1.ins       = 32'hC0DE_0000 + k;
         bus1.ins_valid = 1'b1;
         #1;
         check_output("s1_ready", bus1.ins_ready, 1);
         tick();
         check_output("s1_outs", bus1.outs, 32'hC0DE_0000 + k);
         check_output("s1_index", bus1.index, 0);
         check_output("s1_valid", {bus1.outs_valid, bus1.index_valid}, 2'b11);
      end
      bus1.ins_valid = 1'b0;
      tick();
      check_output("s1_drain", bus1.outs_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one downstream datapath between SIZE elastic producers. Each cycle it picks at most one valid input, registers its data, and emits two elastic channels: the data (`outs`) and the winning input number (`index`). The index channel feeds the select input of a downstream mux or any later consumer that must replay the same ordering. Eager-fork semantics apply to the two outputs: each channel completes its handshake independently, and the slot frees only once both have transferred.

## Interface
Parameters:
- SIZE, 2, number of requester channels (≥1)
- DATA_WIDTH, 32, data width per channel
- INDEX_WIDTH, 1, width of index output; must satisfy 2^INDEX_WIDTH ≥ SIZE

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ins  in  SIZE*DATA_WIDTH  packed input data, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- ins_valid  in  SIZE  per-channel valid
- ins_ready  out  SIZE  per-channel ready; one-hot or zero
- outs  out  DATA_WIDTH  registered selected data
- outs_valid  out  1  data channel valid
- outs_ready  in  1  data channel ready
- index  out  INDEX_WIDTH  registered winner number
- index_valid  out  1  index channel valid
- index_ready  in  1  index channel ready

## Operation
- Slot register: data_r, idx_r, pend_d (data not yet sent), pend_i (index not yet sent). outs_valid = pend_d; index_valid = pend_i.
- Slot empty = !pend_d && !pend_i.
- Done this cycle = (!pend_d || outs_ready) && (!pend_i || index_ready).
- Load allowed = slot empty OR done this cycle, which gives full throughput.
- Round-robin pointer ptr (0..SIZE-1):
  - The winner is the first i with ins_valid[i], scanning ptr, ptr+1, …, wrapping at SIZE-1→0.
  - ins_ready[winner] = load allowed; all other ins_ready bits are 0.
  - ins_ready never asserts for an invalid channel.
- On load (winner exists and load allowed):
  - data_r ← ins[winner]; idx_r ← winner, zero-extended to INDEX_WIDTH.
  - pend_d ← 1; pend_i ← 1.
  - ptr ← winner+1, or 0 if winner = SIZE-1.
- No load while the slot is occupied:
  - pend_d clears on outs_ready; pend_i clears on index_ready, independently.
  - data_r and idx_r hold.
- Done with no valid input: pend_d ← 0, pend_i ← 0; ptr unchanged.
- SIZE=1: ptr stays 0, index is always 0.
- Rules:
  - outs and index are stable while their valid is high.
  - A dropped valid is never re-raised for the same token.
  - Each token emits exactly one data and one index transfer.

## Timing
- Latency: input handshake at cycle N gives outs_valid and index_valid at N+1.
- Throughput: 1 token/cycle when both consumers are always ready.
- ins_ready is combinational from ins_valid, outs_ready, index_ready and state. outs, outs_valid, index and index_valid are pure register outputs.
- Reset (asynchronous, immediate):
  - outs=0, index=0, outs_valid=0, index_valid=0, ptr=0.
  - ins_ready=0 while rst is high.
- Reset mid-operation: any pending token is discarded. After rst deasserts, ptr restarts at 0.
- If both consumers accept on the same cycle as a new input is offered, the slot reloads that edge with no bubble.

## Structure
- No new package types. Index zero-extension and the modulo-SIZE increment are local functions. Add the INDEX_WIDTH ≥ clog2(SIZE) check to the shared elaboration-assert package.
- One sub-module, `rr_arbiter`, holds the ptr register and the combinational rotate/priority pick. Its I/O is req[SIZE], grant_en → grant one-hot, grant_idx. ptr advances when grant_en && |req.
- The top level holds the slot register, pend flags and the fork logic.

## Test plan
- Fairness, SIZE=4, all ins_valid=1, both readies=1, ins[i]=0x10+i:
  - index sequence is 0,1,2,3,0…
  - outs sequence is 0x10,0x11,0x12,0x13,…
  - one token per cycle after 1-cycle latency.
- Skip idle, SIZE=4, ptr=1, only ch3 and ch0 valid:
  - grant ch3 (index=3), then ch0 (index=0).
  - ptr wraps 3→0→1.
- Split fork:
  - Load token idx 2, data 0xAB. Hold index_ready=0 for 3 cycles with outs_ready=1.
  - outs_valid drops after 1 cycle. index_valid=1 with index=2 is held.
  - ins_ready all 0 until index_ready=1, then the next load occurs in the same cycle.
- Backpressure, outs_ready=index_ready=0 for 5 cycles with all inputs valid:
  - outs, index and ins_ready stay stable; ins_ready=0 throughout.
  - no ptr advance.
- Reset mid-token:
  - Assert rst asynchronously (between edges) while pend_d=1.
  - outs_valid=0, index_valid=0 and outs=0 immediately.
  - After release, the first grant goes to the lowest valid channel starting at 0.
- SIZE=1, INDEX_WIDTH=1:
  - a stream of 3 tokens produces index=0 each time, with data passed unchanged.
